// File: rtl/dbus_responder.sv
// Single-port data-bus responder: fixed-latency read/write to a word-wide backing store.
// Every request walks IDLE -> WAIT -> RESP -> GAP, so throughput is bounded by the FSM, not the initiator.
package dbus_pkg;
   typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2, MSIZE8 = 2'd3} dbus_size_e;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [1:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

module dbus_responder
   import dbus_pkg::*;
#(
   parameter int          DEPTH     = 256,
   parameter int          LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       busy,
   output logic       err
);
   localparam int          IW   = $clog2(DEPTH);
   localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

   typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_e;

   state_e      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [63:0] addr_q, data_q, rdata, offset;
   logic [1:0]  size_q;
   logic [7:0]  strobe_q;
   logic [IW-1:0] idx;
   logic        in_range, misaligned, bad, resp_en;

   logic [63:0] mem [DEPTH];

   // Offset wraps for addresses below the base, so one compare covers both bounds.
   assign offset   = addr_q - BASE_ADDR;
   assign in_range = offset < SPAN;
   assign idx      = offset[IW+2:3];
   assign bad      = !in_range || misaligned;
   assign resp_en  = (state == WAIT) && (cnt == 4'd0);

   always_comb begin
      misaligned = 1'b0;
      case (size_q)
         MSIZE1:  misaligned = 1'b0;
         MSIZE2:  misaligned = addr_q[0];
         MSIZE4:  misaligned = |addr_q[1:0];
         default: misaligned = |addr_q[2:0];
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (dreq.valid) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
         end
         WAIT: if (cnt == 4'd0) state_nxt = RESP;
               else cnt_nxt = cnt - 4'd1;
         RESP:    state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         size_q   <= '0;
         strobe_q <= '0;
         rdata    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && dreq.valid) begin
            addr_q   <= dreq.addr;
            data_q   <= dreq.data;
            size_q   <= dreq.size;
            strobe_q <= dreq.strobe;
         end
         rdata <= (resp_en && !bad && strobe_q == 8'd0) ? mem[idx] : '0;
      end
   end

   // Store has no reset; rst_n gating drops a write whose RESP entry edge meets reset.
   always_ff @(posedge clk) begin
      if (rst_n && resp_en && !bad && strobe_q != 8'd0) begin
         for (int i = 0; i < 8; i++)
            if (strobe_q[i]) mem[idx][8*i +: 8] <= data_q[8*i +: 8];
      end
   end

   assign busy  = (state != IDLE);
   assign err   = (state == RESP) && bad;
   assign dresp = '{addr_ok: (state == RESP), data_ok: (state == RESP), data: rdata};

endmodule
